// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg
// Shared definitions for the instruction-fetch / data memory port arbiter.
//   NOP_WORD           : instruction word presented to fetch when no read data is due
//   STARVE_MAX_DEFAULT : default limit on consecutive data grants while fetch waits
//   owner_state_e      : which requester owns the memory read data returning this cycle
package mem_port_arb_pkg;

   localparam logic [31:0] NOP_WORD           = 32'h0000_0013;
   localparam int          STARVE_MAX_DEFAULT = 4;

   // Owner of the previous cycle's memory access. Data writes return nothing,
   // so they map to ST_IDLE just like a cycle with no grant.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IF   = 2'd1,
      ST_DRD  = 2'd2
   } owner_state_e;

endpackage

// File: rtl/mem_port_arb.sv
// mem_port_arb
// Arbitrates a single-ported synchronous memory between an instruction-fetch
// requester and a data (load/store) requester. Data has priority, but a fetch
// that has watched STARVE_MAX data grants in a row wins the next cycle.
//
// Ports
//   clk_i, rst_i        : single clock, synchronous active-high reset
//   if_req_i/if_addr_i  : fetch request and byte address (held until granted)
//   if_gnt_o            : fetch granted this cycle (combinational)
//   if_stall_o          : fetch is requesting but was not granted
//   if_rvalid_o/rdata_o : fetch read data, one cycle after the grant (NOP otherwise)
//   d_req_i .. d_wdata_i: data request, write enable, byte enables, address, write data
//   d_gnt_o             : data granted this cycle (combinational)
//   d_rvalid_o/rdata_o  : data read data, one cycle after a read grant (0 otherwise)
//   mem_*_o             : memory command for the granted requester (all 0 when idle)
//   mem_rdata_i         : memory read data, valid the cycle after mem_en_o
module mem_port_arb
   import mem_port_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_stall_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,

   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_be_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rdata_o,

   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   // A zero STARVE_MAX would give a zero-width counter, so keep at least one bit.
   localparam int              CNT_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [31:0]     WORD_MASK = 32'hFFFF_FFFC;

   logic [CNT_W-1:0] starve_cnt_q;
   logic             starve_hit;
   logic             if_gnt;
   logic             d_gnt;
   owner_state_e     state_q;
   owner_state_e     state_d;

   // Grant decision. Data normally wins; once fetch has been passed over
   // STARVE_MAX times in a row it takes the port. Nothing is granted while
   // reset is held so the memory sees no stray accesses.
   always_comb begin
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      starve_hit = if_req_i && (starve_cnt_q == CNT_MAX);
      if (!rst_i) begin
         if (d_req_i && !starve_hit) begin
            d_gnt = 1'b1;
         end else if (if_req_i) begin
            if_gnt = 1'b1;
         end
      end
   end

   assign if_gnt_o   = if_gnt;
   assign d_gnt_o    = d_gnt;
   assign if_stall_o = if_req_i && !if_gnt && !rst_i;

   // Memory command mux. Addresses are word aligned by masking the byte
   // offset; fetches always read a full word.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (d_gnt) begin
         mem_en_o    = 1'b1;
         mem_we_o    = d_we_i;
         mem_be_o    = d_be_i;
         mem_addr_o  = d_addr_i & WORD_MASK;
         mem_wdata_o = d_wdata_i;
      end else if (if_gnt) begin
         mem_en_o    = 1'b1;
         mem_be_o    = 4'hF;
         mem_addr_o  = if_addr_i & WORD_MASK;
      end
   end

   // Starvation counter: counts data grants that went ahead of a waiting
   // fetch. It restarts whenever fetch is served or stops asking, so only an
   // unbroken run of data grants can force a fetch turn.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt_q <= '0;
      end else if (!if_req_i || if_gnt) begin
         starve_cnt_q <= '0;
      end else if (d_gnt && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end
   end

   // Owner state register: remembers who issued last cycle's read so the
   // returning memory data can be steered to the right requester.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next owner and response routing. A write grant returns nothing, so it
   // leaves the port idle for response purposes. The rvalids are also gated
   // by reset so a read issued just before reset never surfaces.
   always_comb begin
      state_d     = ST_IDLE;
      if_rvalid_o = 1'b0;
      if_rdata_o  = NOP_WORD;
      d_rvalid_o  = 1'b0;
      d_rdata_o   = 32'h0;

      if (if_gnt) begin
         state_d = ST_IF;
      end else if (d_gnt && !d_we_i) begin
         state_d = ST_DRD;
      end

      if (!rst_i) begin
         case (state_q)
            ST_IF: begin
               if_rvalid_o = 1'b1;
               if_rdata_o  = mem_rdata_i;
            end
            ST_DRD: begin
               d_rvalid_o = 1'b1;
               d_rdata_o  = mem_rdata_i;
            end
            default: begin
               if_rvalid_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb
// Directed testbench for mem_port_arb. Grants and memory commands are checked
// in the cycle they are issued; expected read responses are queued with the
// cycle they are due and a separate monitor pops and compares them.
module tb_mem_port_arb;
   import mem_port_arb_pkg::*;

   typedef struct {
      logic [31:0] data;
      int          due;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'h0;
   logic        if_gnt_o;
   logic        if_stall_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [3:0]  d_be_i = 4'h0;
   logic [31:0] d_addr_i = 32'h0;
   logic [31:0] d_wdata_i = 32'h0;
   logic        d_gnt_o;
   logic        d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = 32'hDEAD_BEEF;

   int    checkCount = 0;
   int    errorCount = 0;
   int    cycle = 0;
   resp_t ifQ[$];
   resp_t dQ[$];
   resp_t popped;
   logic  expIf;
   logic  expD;

   mem_port_arb dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_stall_o  (if_stall_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_be_i      (d_be_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_gnt_o     (d_gnt_o),
      .d_rvalid_o  (d_rvalid_o),
      .d_rdata_o   (d_rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Memory contents are a fixed function of the word address.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ 32'h1234_5678;
   endfunction

   // Memory model: returns the addressed word one cycle after an enable,
   // otherwise a junk pattern so stray routing is visible.
   always @(posedge clk) begin
      if (mem_en_o) mem_rdata_i <= memWord(mem_addr_o);
      else          mem_rdata_i <= 32'hDEAD_BEEF;
   end

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cycle, actual, expected);
      end
   endtask

   // Drive one cycle of requests shortly after the clock edge. Asserting
   // reset discards any responses still outstanding.
   task automatic applyStimulus(input logic rst, input logic ifReq, input logic [31:0] ifAddr,
                                input logic dReq, input logic dWe, input logic [3:0] dBe,
                                input logic [31:0] dAddr, input logic [31:0] dWdata);
      @(posedge clk);
      #1;
      rst_i     = rst;
      if_req_i  = ifReq;
      if_addr_i = ifAddr;
      d_req_i   = dReq;
      d_we_i    = dWe;
      d_be_i    = dBe;
      d_addr_i  = dAddr;
      d_wdata_i = dWdata;
      if (rst) begin
         ifQ.delete();
         dQ.delete();
      end
      #1;
   endtask

   // Compare the same-cycle grant/memory outputs and queue the read response
   // the expected grant should produce on the next cycle.
   task automatic checkOutput(input string name, input logic expIfGnt, input logic expDGnt,
                              input logic expStall, input logic expMemEn, input logic expMemWe,
                              input logic [3:0] expMemBe, input logic [31:0] expMemAddr,
                              input logic [31:0] expMemWdata);
      resp_t r;
      checkValue({name, ".if_gnt"}, if_gnt_o, expIfGnt);
      checkValue({name, ".d_gnt"}, d_gnt_o, expDGnt);
      checkValue({name, ".if_stall"}, if_stall_o, expStall);
      checkValue({name, ".mem_en"}, mem_en_o, expMemEn);
      checkValue({name, ".mem_we"}, mem_we_o, expMemWe);
      checkValue({name, ".mem_be"}, mem_be_o, expMemBe);
      checkValue({name, ".mem_addr"}, mem_addr_o, expMemAddr);
      if (!expIfGnt) checkValue({name, ".mem_wdata"}, mem_wdata_o, expMemWdata);
      r.data = memWord(expMemAddr);
      r.due  = cycle + 1;
      if (expIfGnt) ifQ.push_back(r);
      if (expDGnt && !expMemWe) dQ.push_back(r);
   endtask

   // Response monitor: in mid-cycle, any rvalid must match a queued response
   // due this cycle, and idle read data must show the idle value.
   always @(negedge clk) begin
      expIf = (ifQ.size() > 0) && (ifQ[0].due == cycle);
      if (expIf || if_rvalid_o) begin
         checkValue("mon.if_rvalid", if_rvalid_o, expIf);
         if (expIf) begin
            popped = ifQ.pop_front();
            checkValue("mon.if_rdata", if_rdata_o, popped.data);
         end
      end else begin
         checkValue("mon.if_rdata_idle", if_rdata_o, NOP_WORD);
      end

      expD = (dQ.size() > 0) && (dQ[0].due == cycle);
      if (expD || d_rvalid_o) begin
         checkValue("mon.d_rvalid", d_rvalid_o, expD);
         if (expD) begin
            popped = dQ.pop_front();
            checkValue("mon.d_rdata", d_rdata_o, popped.data);
         end
      end else begin
         checkValue("mon.d_rdata_idle", d_rdata_o, 32'h0);
      end
   end

   task automatic idleCycle(input string name);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput(name, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic fetchOnly(input string name, input logic [31:0] addr);
      applyStimulus(1'b0, 1'b1, addr, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput(name, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, addr & 32'hFFFF_FFFC, 32'h0);
   endtask

   task automatic dataReadOnly(input string name, input logic [31:0] addr);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, addr, 32'h0);
      checkOutput(name, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, addr & 32'hFFFF_FFFC, 32'h0);
   endtask

   // Scenario sequence.
   initial begin
      logic [31:0] dAddr;

      // Reset held with both requesters asking: nothing may be granted.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
         checkOutput("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      idleCycle("post_reset_idle");

      // Fetch only, back to back.
      fetchOnly("fetch_00", 32'h00);
      fetchOnly("fetch_04", 32'h04);
      fetchOnly("fetch_08", 32'h08);
      idleCycle("idle_a");

      // Both requesting: data read wins, fetch stalls, then fetch gets its turn.
      applyStimulus(1'b0, 1'b1, 32'h60, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      checkOutput("both_data_100", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      fetchOnly("both_fetch_after", 32'h60);
      idleCycle("idle_b");

      // Continuous data reads with fetch pending: four data grants, one fetch, repeat.
      dAddr = 32'h300;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 4'hF, dAddr, 32'h0);
         if ((i % 5) == 4) begin
            checkOutput("starve_fetch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
         end else begin
            checkOutput("starve_data", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, dAddr, 32'h0);
            dAddr = dAddr + 32'h4;
         end
      end
      idleCycle("idle_c");

      // Partial write to an unaligned address: aligned command, no response.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h203, 32'hCAFE_F00D);
      checkOutput("write_203", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hCAFE_F00D);
      idleCycle("idle_d");

      // Fetch granted, then reset in the next cycle: its response is dropped.
      fetchOnly("fetch_before_reset", 32'h80);
      applyStimulus(1'b1, 1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("reset_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkValue("reset_mid.if_rvalid", if_rvalid_o, 1'b0);
      checkValue("reset_mid.if_rdata", if_rdata_o, 32'h0000_0013);
      idleCycle("after_reset");
      checkValue("after_reset.if_rvalid", if_rvalid_o, 1'b0);
      checkValue("after_reset.if_rdata", if_rdata_o, 32'h0000_0013);

      // Alternating owners: each response goes only to the requester that issued it.
      fetchOnly("alt_fetch_10", 32'h10);
      dataReadOnly("alt_data_20", 32'h20);
      fetchOnly("alt_fetch_14", 32'h14);
      dataReadOnly("alt_data_26", 32'h26);
      idleCycle("drain_1");
      idleCycle("drain_2");

      checkValue("if_queue_drained", ifQ.size(), 0);
      checkValue("d_queue_drained", dQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants issued while a fetch request waits.
REQ-002 SHALL have ports `clk_i` (in, 1, single clock) and `rst_i` (in, 1, synchronous active-high reset), listed first.
REQ-003 SHALL have fetch ports:
- `if_req_i` (in, 1)
- `if_addr_i` (in, 32, byte address)
- `if_gnt_o` (out, 1)
- `if_stall_o` (out, 1, to the fetch stage's stall input)
- `if_rvalid_o` (out, 1)
- `if_rdata_o` (out, 32)
REQ-004 SHALL have data ports:
- `d_req_i` (in, 1)
- `d_we_i` (in, 1)
- `d_be_i` (in, 4)
- `d_addr_i` (in, 32)
- `d_wdata_i` (in, 32)
- `d_gnt_o` (out, 1)
- `d_rvalid_o` (out, 1)
- `d_rdata_o` (out, 32)
REQ-005 SHALL have memory ports:
- `mem_en_o` (out, 1)
- `mem_we_o` (out, 1)
- `mem_be_o` (out, 4)
- `mem_addr_o` (out, 32)
- `mem_wdata_o` (out, 32)
- `mem_rdata_i` (in, 32; valid one cycle after `mem_en_o`)

Function
REQ-006 SHALL grant at most one requester per cycle, combinationally, in the same cycle as the request.
REQ-007 SHALL grant data when `d_req_i`=1, unless `if_req_i`=1 and starve_cnt==STARVE_MAX; in that case fetch is granted.
REQ-008 SHALL grant fetch when `if_req_i`=1 and data is not granted.
REQ-009 SHALL drive `if_stall_o` = `if_req_i` & ~`if_gnt_o`.
REQ-010 SHALL drive the memory port from the granted requester:
- `mem_en_o`=1, with `mem_addr_o` = the granted address with bits [1:0] forced to 0.
- Fetch grant: `mem_we_o`=0, `mem_be_o`=4'hF.
- Data grant: `mem_we_o`/`mem_be_o`/`mem_wdata_o` = `d_we_i`/`d_be_i`/`d_wdata_i`.
- No grant: all memory outputs 0.
REQ-011 starve_cnt (width $clog2(STARVE_MAX+1)) SHALL update as follows:
- Increment, saturating at STARVE_MAX, on each data grant while `if_req_i`=1.
- Clear on any fetch grant or any cycle with `if_req_i`=0.
REQ-012 SHALL track the owner of the previous cycle's memory access with FSM states ST_IDLE, ST_IF, ST_DRD. Next state is:
- ST_IF after a fetch grant.
- ST_DRD after a data read grant.
- ST_IDLE after a data write or no grant.
REQ-013 In ST_IF: `if_rvalid_o`=1 and `if_rdata_o`=`mem_rdata_i`. Otherwise `if_rvalid_o`=0 and `if_rdata_o`=32'h0000_0013 (NOP).
REQ-014 In ST_DRD: `d_rvalid_o`=1 and `d_rdata_o`=`mem_rdata_i`. Otherwise `d_rvalid_o`=0 and `d_rdata_o`=0.
REQ-015 Data writes SHALL complete in the grant cycle and SHALL produce no `d_rvalid_o`.
REQ-016 Back-to-back grants SHALL be supported with no bubble; one access per cycle gives full throughput.
REQ-017 A response to the prior grant and a new grant in the same cycle SHALL be handled independently.
REQ-018 Requests without a grant SHALL have no side effects; the requester holds its request until granted.

Reset
REQ-019 On `rst_i`=1 at a clock edge: state SHALL go to ST_IDLE and starve_cnt SHALL go to 0.
REQ-020 While `rst_i`=1: all grants and rvalids SHALL be 0, `mem_en_o`=0, and `if_stall_o`=0.
REQ-021 A response pending when reset is asserted SHALL be discarded; no rvalid after reset deasserts until a new grant.

Structure
REQ-022 The shared package SHALL hold NOP_WORD (32'h0000_0013), the FSM state encoding, and the STARVE_MAX default.
REQ-023 The block SHALL be a single module with no sub-modules; the starvation counter and owner FSM are inline.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Fetch only, addresses 0x00,0x04,0x08 on consecutive cycles -> `if_gnt_o`=1 each cycle; `if_rvalid_o` the next cycle with matching memory data; `if_stall_o`=0.
- Both requests, data read at 0x100 -> `d_gnt_o`=1, `if_stall_o`=1; `d_rvalid_o` next cycle with mem[0x100]; no `if_rvalid_o` that cycle.
- Continuous data requests with fetch pending, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then the pattern repeats.
- Data write, `d_be_i`=4'b0011, `d_addr_i`=0x203 -> `mem_addr_o`=0x200, `mem_we_o`=1, `mem_be_o`=4'b0011; no `d_rvalid_o` next cycle.
- Fetch grant, then `rst_i` asserted in the following cycle -> no `if_rvalid_o` during or after reset; `if_rdata_o`=0x00000013.
- Alternating fetch/data-read grants -> each response routed only to its owner on the following cycle.
